decode_pipe: RTL and testbench

Registered, parametrised RV32I instruction-decode pipeline stage. It sits between the fetch stage and the register-read/execute stage. It accepts one instruction and PC per cycle over a valid/ready handshake and emits register indices, control selects and one XLEN-wide sign-extended immediate one cycle later. A two-entry skid buffer absorbs downstream backpressure. The stage also supports flush and keeps a saturating stall-cycle counter.

---
 rtl/decode_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - RV32I decode stage with 2-entry skid buffer, flush and stall counter; optional DECODE_ILLEGAL_EN
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [2:0]       out_alu_op,
  output logic             out_alu_alt,
  output logic [1:0]       out_alu_src,
  output logic [2:0]       out_branch_sel,
  output logic             out_mr_sel,
  output logic             out_mw_sel,
  output logic             out_mtr_sel,
  output logic             out_rw_sel,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [2:0]      alu_op;
    logic            alu_alt;
    logic [1:0]      alu_src;
    logic [2:0]      branch_sel;
    logic            mr;
    logic            mw;
    logic            mtr;
    logic            rw;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           dec;
  logic [31:0]      imm32;
  logic [6:0]       opcode;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_xfer, out_xfer;

  assign opcode    = in_instr[6:0];
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Combinational decode of the offered instruction into a pipeline entry
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    case (opcode)
      OPC_OP: begin
        dec.alu_op  = in_instr[14:12];
        dec.alu_alt = in_instr[30];
        dec.rw      = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alu_op  = in_instr[14:12];
        dec.alu_alt = (in_instr[14:12] == 3'b101) && in_instr[30];
        dec.alu_src = 2'b01;
        dec.rw      = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LOAD: begin
        dec.alu_src = 2'b01;
        dec.mr      = 1'b1;
        dec.mtr     = 1'b1;
        dec.rw      = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        dec.alu_src = 2'b01;
        dec.mw      = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.branch_sel = 3'b001;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec.branch_sel = 3'b100;
        dec.rw         = 1'b1;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.branch_sel = 3'b101;
        dec.alu_src    = 2'b01;
        dec.rw         = 1'b1;
        imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LUI: begin
        dec.alu_src = 2'b11;
        dec.rw      = 1'b1;
        imm32       = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.alu_src = 2'b10;
        dec.rw      = 1'b1;
        imm32       = {in_instr[31:12], 12'b0};
      end
      default: ;
    endcase
    dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = (in_instr[1:0] != 2'b11) ||
                  !(opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                   OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC});
    if (dec.illegal) begin
      dec.rw         = 1'b0;
      dec.mr         = 1'b0;
      dec.mw         = 1'b0;
      dec.mtr        = 1'b0;
      dec.branch_sel = 3'b000;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

  // Skid-buffer next state: flush wins over any transfer in the same cycle
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_xfer) begin
          head_d  = dec;
          state_d = S_ONE;
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = dec;
          end else if (in_xfer) begin
            skid_d  = dec;
            state_d = S_TWO;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: if (out_xfer) begin
          head_d  = skid_q;
          state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a valid head is held back
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State, entry and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign out_pc         = head_q.pc;
  assign out_rs1        = head_q.rs1;
  assign out_rs2        = head_q.rs2;
  assign out_rd         = head_q.rd;
  assign out_funct3     = head_q.funct3;
  assign out_alu_op     = head_q.alu_op;
  assign out_alu_alt    = head_q.alu_alt;
  assign out_alu_src    = head_q.alu_src;
  assign out_branch_sel = head_q.branch_sel;
  assign out_mr_sel     = head_q.mr;
  assign out_mw_sel     = head_q.mw;
  assign out_mtr_sel    = head_q.mtr;
  assign out_rw_sel     = head_q.rw;
  assign out_imm        = head_q.imm;
  assign out_illegal    = head_q.illegal;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe at XLEN=64
module tb_decode_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 16;
`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  alu_op;
    logic        alt;
    logic [1:0]  src;
    logic [2:0]  br;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        rw;
    logic [63:0] imm;
    logic        ill;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [2:0]       out_funct3, out_alu_op;
  logic             out_alu_alt;
  logic [1:0]       out_alu_src;
  logic [2:0]       out_branch_sel;
  logic             out_mr_sel, out_mw_sel, out_mtr_sel, out_rw_sel;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  int   total = 0;
  int   bad = 0;
  ent_t exp_q[$];
  bit   dc_q[$];

  decode_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_alu_alt(out_alu_alt),
    .out_alu_src(out_alu_src), .out_branch_sel(out_branch_sel),
    .out_mr_sel(out_mr_sel), .out_mw_sel(out_mw_sel), .out_mtr_sel(out_mtr_sel),
    .out_rw_sel(out_rw_sel), .out_imm(out_imm), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] aop,
                              input logic alt, input logic [1:0] src, input logic [2:0] br,
                              input logic mr, input logic mw, input logic mtr, input logic rw,
                              input logic [63:0] imm, input logic ill);
    ent_t e;
    e = '{pc, rs1, rs2, rd, f3, aop, alt, src, br, mr, mw, mtr, rw, imm, ill};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one instruction until accepted; expectation is queued when acceptance is certain
  task automatic send(input logic [31:0] instr, input ent_t e, input bit src_dc);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = e.pc;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(e);
        dc_q.push_back(src_dc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: instr %08h never accepted", instr);
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every retired entry against the head of the scoreboard
  always @(negedge clk) begin
    ent_t act, e;
    bit   dc;
    if (rst_n && out_valid && out_ready && !flush) begin
      total++;
      act = '{out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_alu_op, out_alu_alt,
              out_alu_src, out_branch_sel, out_mr_sel, out_mw_sel, out_mtr_sel,
              out_rw_sel, out_imm, out_illegal};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got entry pc=%0h with nothing expected", out_pc);
      end else begin
        e  = exp_q.pop_front();
        dc = dc_q.pop_front();
        if (dc) act.src = e.src;
        if (act !== e) begin
          bad++;
          $display("FAIL out_entry pc=%0h: got %h expected %h", e.pc, act, e);
        end
      end
    end
  end

  initial begin
    // asynchronous reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_rw", 64'(out_rw_sel), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming with out_ready=1: one per cycle
    send(32'h002081B3, mk(64'h100, 1, 2, 3, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0), 0);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_pc", out_pc, 64'h100);
    send(32'h06320813, mk(64'h104, 4, 3, 16, 0, 0, 0, 2'b01, 3'b000, 0, 0, 0, 1, 64'd99, 0), 0);
    send(32'hFFF00093, mk(64'h108, 0, 31, 1, 0, 0, 0, 2'b01, 3'b000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0), 0);
    send(32'h00812283, mk(64'h10C, 2, 8, 5, 2, 0, 0, 2'b01, 3'b000, 1, 0, 1, 1, 64'd8, 0), 0);
    send(32'hFE63AE23, mk(64'h110, 7, 6, 28, 2, 0, 0, 2'b01, 3'b000, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0), 0);
    send(32'h40C58533, mk(64'h114, 11, 12, 10, 0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0), 0);
    send(32'h40315093, mk(64'h118, 2, 3, 1, 5, 5, 1, 2'b01, 3'b000, 0, 0, 0, 1, 64'h403, 0), 0);
    send(32'h00208863, mk(64'h11C, 1, 2, 16, 0, 0, 0, 2'b00, 3'b001, 0, 0, 0, 0, 64'd16, 0), 1);
    send(32'hFF9FF0EF, mk(64'h120, 31, 25, 1, 7, 0, 0, 2'b00, 3'b100, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0), 1);
    send(32'h123452B7, mk(64'h124, 8, 3, 5, 5, 0, 0, 2'b11, 3'b000, 0, 0, 0, 1, 64'h1234_5000, 0), 0);
    send(32'h00001117, mk(64'h128, 0, 0, 2, 1, 0, 0, 2'b10, 3'b000, 0, 0, 0, 1, 64'h1000, 0), 0);
    drain("drain_stream");
    chk("stall_stream", 64'(stall_cnt), 64'd0);

    // backpressure: two accepted, third held off while out_ready=0
    out_ready = 1'b0;
    send(32'h002081B3, mk(64'h200, 1, 2, 3, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0), 0);
    send(32'h40C58533, mk(64'h204, 11, 12, 10, 0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0), 0);
    in_valid = 1'b1;
    in_instr = 32'h123452B7;
    in_pc    = 64'h208;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_stall", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    send(32'h123452B7, mk(64'h208, 8, 3, 5, 5, 0, 0, 2'b11, 3'b000, 0, 0, 0, 1, 64'h1234_5000, 0), 0);
    drain("drain_bp");
    chk("bp_stall_after", 64'(stall_cnt), 64'd4);

    // flush while holding two entries, with a third offered
    out_ready = 1'b0;
    send(32'h00812283, mk(64'h300, 2, 8, 5, 2, 0, 0, 2'b01, 3'b000, 1, 0, 1, 1, 64'd8, 0), 0);
    send(32'hFE63AE23, mk(64'h304, 7, 6, 28, 2, 0, 0, 2'b01, 3'b000, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0), 0);
    in_valid = 1'b1;
    in_instr = 32'h06320813;
    in_pc    = 64'h308;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    dc_q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_stall_kept", 64'(stall_cnt), 64'd6);
    @(posedge clk);
    #1;
    chk("flush_not_accepted", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // all-zero word: unsupported opcode
    send(32'h00000000, mk(64'h400, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 64'd0, ILL_EN), 0);
    drain("drain_illegal");

    // asynchronous reset with one entry held
    out_ready = 1'b0;
    send(32'h002081B3, mk(64'h500, 1, 2, 3, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0), 0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    dc_q.delete();
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_pc", out_pc, 64'd0);

    // first rising edge after release accepts
    in_valid  = 1'b1;
    in_instr  = 32'h40C58533;
    in_pc     = 64'h504;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(64'h504, 11, 12, 10, 0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 1, 64'd0, 0));
    dc_q.push_back(1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_rst_first_accept", 64'(out_valid), 64'd1);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
